or1200_vlx_bytepack: RTL and testbench



---
 rtl/or1200_vlx_bytepack.sv | 139 +++++++++++++
 tb/tb_or1200_vlx_bytepack.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_vlx_bytepack.sv
// MSB-first bit accumulator feeding the VLX store unit: packs variable-length
// fields into bytes, stuffs 0x00 after every 0xFF, pads with ones on flush.
module or1200_vlx_bytepack (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_bit_op_i,
  input  logic [31:0] bit_vector_i,
  input  logic [4:0]  num_bits_i,
  input  logic        flush_i,
  input  logic        byte_ack_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        stall_o,
  output logic [5:0]  bit_cnt_o
);

  typedef enum logic [1:0] {IDLE, SEND, STUFF} state_e;

  state_e      state_q, state_d;
  logic [39:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;

  logic [31:0] field;
  logic [39:0] acc_app, acc_pad;
  logic [5:0]  cnt_app, cnt_sub;
  logic [3:0]  pad_n;

  // Oldest 8 valid bits: acc[cnt-1 -: 8]; only meaningful when cnt >= 8.
  function automatic logic [7:0] top_byte(input logic [39:0] acc, input logic [5:0] cnt);
    return 8'(acc >> (cnt - 6'd8));
  endfunction

  always_comb begin
    field   = bit_vector_i & ((32'd1 << num_bits_i) - 32'd1);
    acc_app = (acc_q << num_bits_i) | {8'd0, field};
    cnt_app = cnt_q + {1'b0, num_bits_i};
    pad_n   = 4'd8 - {1'b0, cnt_q[2:0]};
    acc_pad = (acc_q << pad_n) | ((40'd1 << pad_n) - 40'd1);
    cnt_sub = cnt_q - 6'd8;
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    byte_d       = byte_q;
    valid_d      = valid_q;

    unique case (state_q)
      IDLE: begin
        if (cnt_q >= 6'd8) begin
          state_d = SEND;
          byte_d  = top_byte(acc_q, cnt_q);
          valid_d = 1'b1;
        end else if (flush_pend_q) begin
          flush_pend_d = 1'b0;
          if (cnt_q != 6'd0) begin
            acc_d   = acc_pad;
            cnt_d   = 6'd8;
            state_d = SEND;
            byte_d  = acc_pad[7:0];
            valid_d = 1'b1;
          end
        end else begin
          // stall_o is low on this path, so both strobes are accepted here.
          if (set_bit_op_i) begin
            acc_d = acc_app;
            cnt_d = cnt_app;
            if (cnt_app >= 6'd8) begin
              state_d = SEND;
              byte_d  = top_byte(acc_app, cnt_app);
              valid_d = 1'b1;
            end
          end
          if (flush_i) flush_pend_d = 1'b1;
        end
      end

      SEND: begin
        if (byte_ack_i) begin
          cnt_d = cnt_sub;
          if (byte_q == 8'hFF) begin
            state_d = STUFF;
            byte_d  = 8'h00;
          end else if (cnt_sub >= 6'd8) begin
            byte_d = top_byte(acc_q, cnt_sub);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end

      STUFF: begin
        if (byte_ack_i) begin
          if (cnt_q >= 6'd8) begin
            state_d = SEND;
            byte_d  = top_byte(acc_q, cnt_q);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      byte_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      byte_q       <= byte_d;
      valid_q      <= valid_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign bit_cnt_o    = cnt_q;
  assign stall_o      = (state_q != IDLE) | (cnt_q >= 6'd8) | flush_pend_q;

endmodule

// File: tb/tb_or1200_vlx_bytepack.sv
// Scoreboard bench for the byte packer: a bit-queue model predicts the byte
// stream; a monitor drives byte_ack_i and checks every accepted byte.
module tb_or1200_vlx_bytepack;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        set_bit_op_i = 1'b0;
  logic [31:0] bit_vector_i = '0;
  logic [4:0]  num_bits_i = '0;
  logic        flush_i = 1'b0;
  logic        byte_ack_i = 1'b0;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        stall_o;
  logic [5:0]  bit_cnt_o;

  int checks = 0;
  int errors = 0;

  bit         bits_q[$];   // model: pending bits, oldest first
  logic [7:0] exp_q[$];    // expected byte stream
  int         ack_mode = 1; // 0 random, 1 always, 2 never

  logic       prev_hold = 1'b0;
  logic [7:0] prev_byte = '0;

  or1200_vlx_bytepack dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .set_bit_op_i (set_bit_op_i),
    .bit_vector_i (bit_vector_i),
    .num_bits_i   (num_bits_i),
    .flush_i      (flush_i),
    .byte_ack_i   (byte_ack_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .stall_o      (stall_o),
    .bit_cnt_o    (bit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_drain();
    logic [7:0] b;
    while (bits_q.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], logic'(bits_q.pop_front())};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  task automatic model_append(input logic [4:0] n, input logic [31:0] v);
    for (int i = int'(n) - 1; i >= 0; i--) bits_q.push_back(bit'(v[i]));
    model_drain();
  endtask

  task automatic model_flush();
    if (bits_q.size() > 0) begin
      while (bits_q.size() < 8) bits_q.push_back(1'b1);
      model_drain();
    end
  endtask

  // Monitor: choose ack for the coming edge, then score any byte it consumes.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_hold  = 1'b0;
      byte_ack_i = 1'b0;
    end else begin
      if (prev_hold) check("hold_stable", {byte_valid_o, byte_o}, {1'b1, prev_byte});
      if (byte_valid_o) check("stall_in_send", stall_o, 1'b1);
      case (ack_mode)
        1:       byte_ack_i = 1'b1;
        2:       byte_ack_i = 1'b0;
        default: byte_ack_i = ($urandom_range(0, 2) != 0);
      endcase
      if (byte_valid_o && byte_ack_i) begin
        if (exp_q.size() == 0) check("unexpected_byte", byte_o, 40'hDEAD);
        else check("byte", byte_o, exp_q.pop_front());
      end
      prev_hold = byte_valid_o && !byte_ack_i;
      prev_byte = byte_o;
    end
  end

  // Returns at a negedge with stall_o low; confirms the model has drained too.
  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!stall_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle: stall_o still %0b after 1000 cycles", stall_o);
    end else begin
      check("idle_cnt", bit_cnt_o, 40'(bits_q.size()));
      check("idle_queue_empty", 40'(exp_q.size()), 40'd0);
    end
  endtask

  task automatic do_op(input logic set, input logic [4:0] n, input logic [31:0] v, input logic fl);
    wait_idle();
    set_bit_op_i = set;
    num_bits_i   = n;
    bit_vector_i = v;
    flush_i      = fl;
    if (set) model_append(n, v);
    if (fl) model_flush();
    @(negedge clk_i);
    set_bit_op_i = 1'b0;
    flush_i      = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [2:0] r;
    logic [31:0] v;

    #3;
    check("rst_byte", byte_o, 8'h00);
    check("rst_valid", byte_valid_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_cnt", bit_cnt_o, 6'd0);
    #9 rst_i = 1'b0;
    @(negedge clk_i);

    // 101 + 10110 -> 0xB6, stall only while sending
    ack_mode = 1;
    do_op(1'b1, 5'd3, 32'b101, 1'b0);
    check("t1_stall_partial", stall_o, 1'b0);
    do_op(1'b1, 5'd5, 32'b10110, 1'b0);
    check("t1_valid", byte_valid_o, 1'b1);
    check("t1_byte", byte_o, 8'hB6);
    check("t1_stall_send", stall_o, 1'b1);
    @(negedge clk_i);
    check("t1_valid_after", byte_valid_o, 1'b0);
    check("t1_stall_after", stall_o, 1'b0);
    check("t1_cnt_after", bit_cnt_o, 6'd0);

    // 0xFF followed by stuffed 0x00
    do_op(1'b1, 5'd8, 32'hFFFF_FFFF, 1'b0);
    check("t2_byte_ff", byte_o, 8'hFF);
    @(negedge clk_i);
    check("t2_stuff", {byte_valid_o, byte_o}, {1'b1, 8'h00});
    check("t2_stall_stuff", stall_o, 1'b1);
    @(negedge clk_i);
    check("t2_stall_released", stall_o, 1'b0);

    // 010 + flush -> 0x5F; flush with nothing pending emits nothing
    do_op(1'b1, 5'd3, 32'b010, 1'b0);
    do_op(1'b0, 5'd0, 32'd0, 1'b1);
    check("t3_flush_pend_stall", {stall_o, byte_valid_o}, 2'b10);
    @(negedge clk_i);
    check("t3_pad_byte", {byte_valid_o, byte_o}, {1'b1, 8'h5F});
    @(negedge clk_i);
    do_op(1'b0, 5'd0, 32'd0, 1'b1);
    check("t3_empty_flush_pend", {stall_o, byte_valid_o}, 2'b10);
    @(negedge clk_i);
    check("t3_empty_flush_done", {stall_o, byte_valid_o}, 2'b00);
    check("t3_cnt", bit_cnt_o, 6'd0);

    // 7 ones + 31 zeros -> FE 00 00 00, 6 bits left
    ack_mode = 0;
    do_op(1'b1, 5'd7, 32'h7F, 1'b0);
    do_op(1'b1, 5'd31, 32'h0, 1'b0);
    wait_idle();
    check("t4_cnt", bit_cnt_o, 6'd6);

    // held ack: output stable, append while stalled ignored
    ack_mode = 2;
    @(negedge clk_i);
    @(negedge clk_i);
    do_op(1'b0, 5'd0, 32'd0, 1'b1);   // flush the 6 leftover bits first
    @(negedge clk_i);
    ack_mode = 1;
    wait_idle();
    ack_mode = 2;
    @(negedge clk_i);
    @(negedge clk_i);
    do_op(1'b1, 5'd16, 32'hA55A, 1'b0);
    check("t5_first", {byte_valid_o, byte_o}, {1'b1, 8'hA5});
    for (int i = 0; i < 10; i++) begin
      set_bit_op_i = (i == 3);
      num_bits_i   = 5'd8;
      bit_vector_i = 32'h12;
      @(negedge clk_i);
      check("t5_hold_cnt", bit_cnt_o, 6'd16);
    end
    set_bit_op_i = 1'b0;
    ack_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (byte_valid_o && byte_o == 8'h5A) found = 1'b1;
    end
    check("t5_second_seen", found, 1'b1);
    check("t5_cnt_minus8", bit_cnt_o, 6'd8);
    wait_idle();

    // asynchronous reset while a byte is waiting
    ack_mode = 2;
    @(negedge clk_i);
    @(negedge clk_i);
    do_op(1'b1, 5'd16, 32'hBEEF, 1'b0);
    check("t6_pre_valid", byte_valid_o, 1'b1);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("t6_rst_valid", byte_valid_o, 1'b0);
    check("t6_rst_stall", stall_o, 1'b0);
    check("t6_rst_cnt", bit_cnt_o, 6'd0);
    exp_q.delete();
    bits_q.delete();
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    ack_mode = 1;
    @(negedge clk_i);
    do_op(1'b1, 5'd8, 32'h3C, 1'b0);
    check("t6_after_rst", {byte_valid_o, byte_o}, {1'b1, 8'h3C});
    wait_idle();

    // randomized traffic against the bit-queue model
    ack_mode = 0;
    for (int k = 0; k < 300; k++) begin
      r = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      case (r)
        3'd0:    do_op(1'b0, 5'd0, 32'd0, 1'b1);
        3'd1:    do_op(1'b1, 5'($urandom_range(0, 31)), v, 1'b1);
        default: do_op(1'b1, 5'($urandom_range(0, 31)), v, 1'b0);
      endcase
    end
    do_op(1'b0, 5'd0, 32'd0, 1'b1);
    ack_mode = 1;
    wait_idle();
    check("final_cnt_zero", bit_cnt_o, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
